fwrite_engine: RTL and testbench
================================

Name: fwrite_engine

Overview:
- Parametrised hardware successor to the compiled fwrite/__mulsi3 routine.
- Copies size*nmemb bytes from a memory source to a target address over the shared single-outstanding memory bus (addr/size/valid/write/wdata/rdata/ready).
- The target is either a fixed port (stream mode) or an incrementing destination (copy mode).
- Adds features the compiled routine lacks: data-width and length generalisation, a start/done handshake, abort, and a byte counter.

Parameters:
- DATA_W, 32, bus data width; must be 32 or 64; byte lanes = DATA_W/8.
- ADDR_W, 32, bus address width.
- MUL_W, 16, operand width of the size and nmemb inputs.
- LEN_W, 32, width of the total-length register; the product is truncated to LEN_W bits.
- DST_INC, 0, target mode: 0 = fixed port address, 1 = destination increments per byte.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  level; stop after the current bus transaction
- src  in  ADDR_W  source base address
- dst  in  ADDR_W  port or destination base address
- elem_size  in  MUL_W  bytes per element
- nmemb  in  MUL_W  element count
- idle  out  1  high in IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with done; high if terminated by abort
- ret  out  MUL_W  return value, valid with done
- bytes_done  out  LEN_W  bytes written so far
- addr  out  ADDR_W  bus address
- size  out  3  bus size code: 0 = byte, 1 = half, 2 = word
- valid  out  1  bus request
- write  out  1  1 = store, 0 = load
- wdata  out  DATA_W  store data, lane-aligned
- rdata  in  DATA_W  load data
- ready  in  1  bus completion

Behaviour:
- Reset (rstb low, asynchronous):
  - idle=1; done=0; aborted=0; valid=0; write=0.
  - size=0; addr=0; wdata=0; ret=0; bytes_done=0.
  - State returns to IDLE. Reset mid-transaction drops valid immediately and does not complete the transaction.
- States: IDLE, MUL, RD, WR, FIN.
- IDLE:
  - On start: latch src, dst, elem_size, nmemb; clear the product, index and bytes_done; idle=0; go to MUL.
- MUL (shift-add, one bit per cycle):
  - If multiplier bit0 is set, product += multiplicand.
  - Each cycle the multiplicand shifts left 1 and the multiplier shifts right 1.
  - Exit when the multiplier is 0, so latency is position of the highest set bit + 1 cycles, at most MUL_W. A zero operand exits after 1 cycle.
  - The product is unsigned and truncated to LEN_W.
  - Next state: product==0 goes to FIN; otherwise RD.
- RD:
  - Drive valid=1, write=0, size=0, addr=src+i.
  - Hold addr until ready is sampled high.
  - On the valid&&ready edge:
    - Capture the byte at rdata >> 8*addr[log2(DATA_W/8)-1:0].
    - Drop valid on the same edge.
    - Go to WR.
- WR:
  - Drive valid=1, write=1, size=0.
  - addr = dst (DST_INC=0) or dst+i (DST_INC=1).
  - wdata = byte << 8*lane(addr); all other lanes 0.
  - On the valid&&ready edge:
    - Drop valid; i += 1; bytes_done += 1.
    - If abort is high or i == product, go to FIN; else go to RD.
- Bus timing:
  - Minimum 2 cycles per transaction.
  - One transaction outstanding at a time.
  - valid never rises in the same cycle it fell.
  - addr, write and wdata are stable while valid is high.
- Abort:
  - Sampled in RD and WR only.
  - In RD with valid high, the read completes and is discarded, then go to FIN.
  - Abort never drops valid before ready.
  - Abort in MUL or IDLE is ignored.
- FIN (one cycle):
  - done=1; idle returns to 1 on the next cycle.
  - ret = nmemb when completed normally; ret = 0 and aborted=1 when aborted.
  - bytes_done holds its value until the next start.
- Other rules:
  - start while not in IDLE is ignored.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - ready seen while valid is low is ignored.

Test Plan:
- Stream, DATA_W=32, DST_INC=0, src=0x100, dst=0x2003, elem_size=3, nmemb=2, memory 0x100..0x105 = 41..46:
  - 6 reads followed by 6 byte writes to 0x2003; each wdata = byte<<24.
  - done with ret=2 and bytes_done=6.
- Zero length, elem_size=0, nmemb=5:
  - MUL takes 1 cycle, then done with ret=5; valid never asserted.
- Copy, DST_INC=1, DATA_W=64, src=0x7, dst=0x10, elem_size=1, nmemb=4:
  - Read lanes are 7, 0, 1, 2 (src 0x7..0xA); write addresses are 0x10..0x13 on lanes 0..3.
- Bus stall: ready held low for 5 cycles on the first read:
  - valid and addr stay constant for 5 cycles; total latency grows by exactly 5.
- Abort asserted during the 3rd read (valid high) of a 10-byte job:
  - The read completes and no 3rd write occurs.
  - done with aborted=1, ret=0, bytes_done=2.
- Reset pulse during a WR with valid=1:
  - Outputs take their reset values immediately.
  - A start after reset runs the job from i=0.

Source files
------------

// File: rtl/fwrite_engine_if.sv
// Shared single-outstanding memory bus between the fwrite engine (master) and memory (slave).
// Latency: none, wires only; a transaction completes on the edge where valid && ready.
// Backpressure: the slave holds ready low to stall; the master keeps addr/write/wdata stable meanwhile.
//
// Signals: addr/size/valid/write/wdata driven by the master, rdata/ready driven by the slave.
interface fwrite_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic              valid;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output addr, size, valid, write, wdata, input rdata, ready);
    modport slave  (input addr, size, valid, write, wdata, output rdata, ready);
endinterface

// File: rtl/fwrite_engine.sv
// Copies elem_size*nmemb bytes from src to a fixed port (DST_INC=0) or incrementing dst (DST_INC=1).
// Latency: 1 + multiply cycles (highest set bit of nmemb + 1) + 4 cycles per byte with zero bus stall.
// Backpressure: each bus request is held until ready; abort takes effect only at a transaction boundary.
//
// Ports: clk, rstb (async active-low); start/abort control; src, dst, elem_size, nmemb job
// parameters; idle/done/aborted/ret/bytes_done status; bus = memory master port.
module fwrite_engine #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MUL_W   = 16,
    parameter int LEN_W   = 32,
    parameter bit DST_INC = 1'b0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [MUL_W-1:0]  elem_size,
    input  logic [MUL_W-1:0]  nmemb,
    output logic              idle,
    output logic              done,
    output logic              aborted,
    output logic [MUL_W-1:0]  ret,
    output logic [LEN_W-1:0]  bytes_done,
    fwrite_engine_if.master   bus
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_RD, S_WR, S_FIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  src_q, dst_q, addr_q;
    logic [MUL_W-1:0]   nmemb_q, mplier;
    logic [LEN_W-1:0]   mcand, product, idx;
    logic [7:0]         byte_q;
    logic               valid_q, write_q, aborted_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [LEN_W-1:0]   prod_nxt, idx_inc;
    logic               mul_last, xfer, fin_abort;
    logic [ADDR_W-1:0]  rd_addr, wr_addr;

    // Shift-add multiply: nmemb is the multiplier, elem_size the multiplicand.
    // A zero multiplicand cannot change the product, so it finishes at once.
    assign prod_nxt = mplier[0] ? product + mcand : product;
    assign mul_last = ((mplier >> 1) == '0) || (mcand == '0);

    assign xfer    = valid_q && bus.ready;
    assign idx_inc = idx + LEN_W'(1);
    assign rd_addr = src_q + ADDR_W'(idx);
    assign wr_addr = DST_INC ? dst_q + ADDR_W'(idx) : dst_q;

    // Abort ends the job either before a read is issued or when a read/write completes.
    assign fin_abort = abort && (((state == S_RD) && (!valid_q || bus.ready)) ||
                                 ((state == S_WR) && xfer));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_MUL;
            S_MUL:  if (mul_last) state_nxt = (prod_nxt == '0) ? S_FIN : S_RD;
            S_RD: begin
                if (!valid_q) begin
                    if (abort) state_nxt = S_FIN;
                end else if (bus.ready) begin
                    state_nxt = abort ? S_FIN : S_WR;
                end
            end
            S_WR: begin
                if (xfer) state_nxt = (abort || idx_inc == product) ? S_FIN : S_RD;
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            src_q      <= '0;
            dst_q      <= '0;
            nmemb_q    <= '0;
            mcand      <= '0;
            mplier     <= '0;
            product    <= '0;
            idx        <= '0;
            byte_q     <= '0;
            bytes_done <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            ret        <= '0;
            aborted_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        src_q      <= src;
                        dst_q      <= dst;
                        nmemb_q    <= nmemb;
                        mcand      <= LEN_W'(elem_size);
                        mplier     <= nmemb;
                        product    <= '0;
                        idx        <= '0;
                        bytes_done <= '0;
                    end
                end
                S_MUL: begin
                    product <= prod_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                end
                S_RD: begin
                    if (!valid_q) begin
                        if (!abort) begin
                            valid_q <= 1'b1;
                            write_q <= 1'b0;
                            addr_q  <= rd_addr;
                        end
                    end else if (bus.ready) begin
                        valid_q <= 1'b0;
                        byte_q  <= 8'(bus.rdata >> {addr_q[LANE_W-1:0], 3'b000});
                    end
                end
                S_WR: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        write_q <= 1'b1;
                        addr_q  <= wr_addr;
                        wdata_q <= DATA_W'(byte_q) << {wr_addr[LANE_W-1:0], 3'b000};
                    end else if (bus.ready) begin
                        valid_q    <= 1'b0;
                        idx        <= idx_inc;
                        bytes_done <= bytes_done + LEN_W'(1);
                    end
                end
                default: ;
            endcase

            // Result is latched on entry to FIN so it is valid for the whole done cycle.
            if (state_nxt == S_FIN && state != S_FIN) begin
                ret       <= fin_abort ? '0 : nmemb_q;
                aborted_q <= fin_abort;
            end
        end
    end

    assign idle      = (state == S_IDLE);
    assign done      = (state == S_FIN);
    assign aborted   = aborted_q && done;
    assign bus.addr  = addr_q;
    assign bus.size  = 3'd0;
    assign bus.valid = valid_q;
    assign bus.write = write_q;
    assign bus.wdata = wdata_q;
endmodule

// File: tb/tb_fwrite_engine.sv
// Directed bench for fwrite_engine: 32-bit stream instance (a) and 64-bit copy instance (b).
// Latency: expected job latencies are hand-computed from multiply cycles + 4 cycles per byte.
// Backpressure: memory model answers immediately, except a 5-cycle stall on reads of 0x100 when armed.
module tb_fwrite_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, start_a, start_b, abort;
    logic [31:0] src, dst;
    logic [15:0] elem_size, nmemb;
    logic        idle_a, done_a, aborted_a, idle_b, done_b, aborted_b;
    logic [15:0] ret_a, ret_b;
    logic [31:0] bytes_a, bytes_b;

    fwrite_engine_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    fwrite_engine_if #(.DATA_W(64), .ADDR_W(32)) bus_b ();

    fwrite_engine #(.DATA_W(32), .ADDR_W(32), .MUL_W(16), .LEN_W(32), .DST_INC(1'b0)) u_a (
        .clk(clk), .rstb(rstb), .start(start_a), .abort(abort), .src(src), .dst(dst),
        .elem_size(elem_size), .nmemb(nmemb), .idle(idle_a), .done(done_a),
        .aborted(aborted_a), .ret(ret_a), .bytes_done(bytes_a), .bus(bus_a.master));

    fwrite_engine #(.DATA_W(64), .ADDR_W(32), .MUL_W(16), .LEN_W(32), .DST_INC(1'b1)) u_b (
        .clk(clk), .rstb(rstb), .start(start_b), .abort(abort), .src(src), .dst(dst),
        .elem_size(elem_size), .nmemb(nmemb), .idle(idle_b), .done(done_b),
        .aborted(aborted_b), .ret(ret_b), .bytes_done(bytes_b), .bus(bus_b.master));

    // Memory contents: 0x100..0x105 hold 41..46, everything else holds low address byte + 0x30.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a >= 32'h100 && a <= 32'h105) return 8'd41 + 8'(a - 32'h100);
        return a[7:0] + 8'h30;
    endfunction

    // Unselected lanes carry 0xEE so a wrong lane pick is visible.
    always_comb begin
        bus_a.rdata = {4{8'hEE}};
        bus_a.rdata[8*bus_a.addr[1:0] +: 8] = mem_byte(bus_a.addr);
        bus_b.rdata = {8{8'hEE}};
        bus_b.rdata[8*bus_b.addr[2:0] +: 8] = mem_byte(bus_b.addr);
    end

    logic stall_on = 1'b0;
    int   stall_left = 0;
    logic stall_hit;
    assign stall_hit   = bus_a.valid && !bus_a.write && bus_a.addr == 32'h100 && stall_left != 0;
    assign bus_a.ready = bus_a.valid && !stall_hit;
    assign bus_b.ready = bus_b.valid;

    always @(posedge clk) begin
        if (!bus_a.valid)   stall_left <= stall_on ? 5 : 0;
        else if (stall_hit) stall_left <= stall_left - 1;
    end

    logic [63:0] rd_log[$];
    logic [63:0] wa_log[$];
    logic [63:0] wd_log[$];
    int          vld_cnt = 0;

    always @(posedge clk) begin
        if (bus_a.valid && bus_a.ready) begin
            if (bus_a.write) begin
                wa_log.push_back(64'(bus_a.addr));
                wd_log.push_back(64'(bus_a.wdata));
            end else rd_log.push_back(64'(bus_a.addr));
        end
        if (bus_b.valid && bus_b.ready) begin
            if (bus_b.write) begin
                wa_log.push_back(64'(bus_b.addr));
                wd_log.push_back(bus_b.wdata);
            end else rd_log.push_back(64'(bus_b.addr));
        end
        if (bus_a.valid || bus_b.valid) vld_cnt <= vld_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int rd_base, wr_base, n_stall;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Returns at the negedge where done is high (lat = edges from start),
    // or right after pulling rstb low at write index rst_wr (lat = -2).
    task automatic run_job(input bit sel, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] es, input logic [15:0] nm,
                           input int abort_rd, input int rst_wr, output int lat);
        src = s; dst = d; elem_size = es; nmemb = nm;
        rd_base = rd_log.size();
        wr_base = wa_log.size();
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        lat = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (abort_rd >= 0 && bus_a.valid && !bus_a.write && rd_log.size() - rd_base == abort_rd)
                abort = 1'b1;
            if (rst_wr >= 0 && bus_a.valid && bus_a.write && wa_log.size() - wr_base == rst_wr) begin
                rstb = 1'b0;
                lat = -2;
                return;
            end
            if (stall_on && stall_hit) begin
                chk("stall_addr", 64'(bus_a.addr), 64'h100);
                n_stall++;
            end
            if (sel ? done_b : done_a) return;
        end
        chk("timeout_done", 64'(sel ? done_b : done_a), 64'd1);
        lat = -1;
    endtask

    logic [31:0] exp_wd_a [6] = '{32'h2900_0000, 32'h2A00_0000, 32'h2B00_0000,
                                  32'h2C00_0000, 32'h2D00_0000, 32'h2E00_0000};
    logic [63:0] exp_wd_b [4] = '{64'h0000_0037, 64'h0000_3800, 64'h0039_0000, 64'h3A00_0000};

    initial begin
        int lat, lat0, vb;
        rstb = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        src = '0; dst = '0; elem_size = '0; nmemb = '0; n_stall = 0;
        repeat (2) @(negedge clk);
        chk("rst_idle",  64'(idle_a), 64'd1);
        chk("rst_done",  64'(done_a), 64'd0);
        chk("rst_abtd",  64'(aborted_a), 64'd0);
        chk("rst_valid", 64'(bus_a.valid), 64'd0);
        chk("rst_write", 64'(bus_a.write), 64'd0);
        chk("rst_size",  64'(bus_a.size), 64'd0);
        chk("rst_addr",  64'(bus_a.addr), 64'd0);
        chk("rst_wdata", 64'(bus_a.wdata), 64'd0);
        chk("rst_ret",   64'(ret_a), 64'd0);
        chk("rst_bytes", 64'(bytes_a), 64'd0);
        rstb = 1'b1;
        @(negedge clk);

        // Stream: 3 x 2 bytes to fixed port 0x2003 (lane 3). 2 multiply cycles + 24 + 1.
        run_job(1'b0, 32'h100, 32'h2003, 16'd3, 16'd2, -1, -1, lat);
        chk("s_lat",   64'(lat), 64'd27);
        chk("s_ret",   64'(ret_a), 64'd2);
        chk("s_bytes", 64'(bytes_a), 64'd6);
        chk("s_abtd",  64'(aborted_a), 64'd0);
        chk("s_nrd",   64'(rd_log.size() - rd_base), 64'd6);
        chk("s_nwr",   64'(wa_log.size() - wr_base), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk("s_rd_addr", rd_log[rd_base + k], 64'h100 + 64'(k));
            chk("s_wr_addr", wa_log[wr_base + k], 64'h2003);
            chk("s_wdata",   wd_log[wr_base + k], 64'(exp_wd_a[k]));
        end
        @(negedge clk);
        chk("s_idle_after", 64'(idle_a), 64'd1);
        chk("s_done_pulse", 64'(done_a), 64'd0);

        // Zero length: elem_size=0 exits multiply after one cycle, no bus traffic.
        vb = vld_cnt;
        run_job(1'b0, 32'h300, 32'h400, 16'd0, 16'd5, -1, -1, lat);
        chk("z_lat",   64'(lat), 64'd2);
        chk("z_ret",   64'(ret_a), 64'd5);
        chk("z_bytes", 64'(bytes_a), 64'd0);
        chk("z_valid", 64'(vld_cnt - vb), 64'd0);
        @(negedge clk);

        // Copy on the 64-bit instance: nmemb=4 needs 3 multiply cycles; 1 + 3 + 16.
        run_job(1'b1, 32'h7, 32'h10, 16'd1, 16'd4, -1, -1, lat);
        chk("c_lat",   64'(lat), 64'd20);
        chk("c_ret",   64'(ret_b), 64'd4);
        chk("c_bytes", 64'(bytes_b), 64'd4);
        chk("c_nwr",   64'(wa_log.size() - wr_base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("c_rd_addr", rd_log[rd_base + k], 64'h7 + 64'(k));
            chk("c_wr_addr", wa_log[wr_base + k], 64'h10 + 64'(k));
            chk("c_wdata",   wd_log[wr_base + k], exp_wd_b[k]);
        end
        @(negedge clk);

        // Stall: same 3-byte job without and with a 5-cycle stall on the first read.
        run_job(1'b0, 32'h100, 32'h2000, 16'd3, 16'd1, -1, -1, lat0);
        chk("st_base_lat", 64'(lat0), 64'd14);
        @(negedge clk);
        stall_on = 1'b1;
        n_stall = 0;
        @(negedge clk);
        run_job(1'b0, 32'h100, 32'h2000, 16'd3, 16'd1, -1, -1, lat);
        stall_on = 1'b0;
        chk("st_lat",    64'(lat), 64'd19);
        chk("st_delta",  64'(lat - lat0), 64'd5);
        chk("st_cycles", 64'(n_stall), 64'd5);
        chk("st_wdata0", wd_log[wr_base], 64'h29);
        chk("st_bytes",  64'(bytes_a), 64'd3);
        @(negedge clk);

        // Abort during the 3rd read of a 10-byte job.
        run_job(1'b0, 32'h100, 32'h2000, 16'd2, 16'd5, 2, -1, lat);
        abort = 1'b0;
        chk("ab_abtd",  64'(aborted_a), 64'd1);
        chk("ab_ret",   64'(ret_a), 64'd0);
        chk("ab_bytes", 64'(bytes_a), 64'd2);
        chk("ab_nrd",   64'(rd_log.size() - rd_base), 64'd3);
        chk("ab_nwr",   64'(wa_log.size() - wr_base), 64'd2);
        @(negedge clk);
        chk("ab_idle",  64'(idle_a), 64'd1);

        // Reset during the 2nd write with valid high, then rerun from scratch.
        run_job(1'b0, 32'h100, 32'h2003, 16'd3, 16'd2, -1, 1, lat);
        #1;
        chk("r_lat_tag", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("r_valid", 64'(bus_a.valid), 64'd0);
        chk("r_write", 64'(bus_a.write), 64'd0);
        chk("r_idle",  64'(idle_a), 64'd1);
        chk("r_addr",  64'(bus_a.addr), 64'd0);
        chk("r_wdata", 64'(bus_a.wdata), 64'd0);
        chk("r_bytes", 64'(bytes_a), 64'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        run_job(1'b0, 32'h100, 32'h2003, 16'd3, 16'd2, -1, -1, lat);
        chk("r2_lat",   64'(lat), 64'd27);
        chk("r2_bytes", 64'(bytes_a), 64'd6);
        chk("r2_rd0",   rd_log[rd_base], 64'h100);
        chk("r2_wd0",   wd_log[wr_base], 64'h2900_0000);
        chk("r2_nwr",   64'(wa_log.size() - wr_base), 64'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
